// File: rtl/arb_pkg.sv
// Shared constants and helpers for the arbitrating multiplexer.
package arb_pkg;

    // Arbitration policy selectors.
    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // Channel-tag width: ceil(log2(n)), never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational arbiter: round-robin from ptr, or fixed priority (lowest index).
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = clog2_min1(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  ptr,
    input  logic           en,
    input  logic           mode,
    output logic [NCH-1:0] gnt,
    output logic [CW-1:0]  gnt_idx
);

    localparam int unsigned N = NCH;

    logic [2*NCH-1:0] rot;
    int unsigned      start;
    int unsigned      off;
    int unsigned      idx;
    logic             found;

    // Rotate requests so the search start sits at bit 0, take the lowest
    // set bit, then map the offset back to an absolute channel index.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        off     = 0;
        idx     = 0;
        start   = mode ? 0 : 32'(ptr);
        rot     = {req, req} >> start;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = k;
            end
        end
        idx = start + off;
        if (idx >= N) begin
            idx = idx - N;
        end
        if (en && found) begin
            gnt_idx = CW'(idx);
            for (int unsigned i = 0; i < N; i++) begin
                gnt[i] = (i == idx);
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrating multiplexer with a registered, channel-tagged output.
module arb_mux
    import arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int MODE  = MODE_RR
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NCH-1:0]             in_valid,
    input  logic [NCH*WIDTH-1:0]       in_data,
    output logic [NCH-1:0]             in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [clog2_min1(NCH)-1:0] out_ch,
    input  logic                       out_ready
);

    localparam int CW = clog2_min1(NCH);

    if (NCH < 1 || (MODE != MODE_RR && MODE != MODE_FIXED)) begin : g_bad_params
        $error("arb_mux: illegal parameters NCH=%0d MODE=%0d", NCH, MODE);
    end

    logic [NCH-1:0]   gnt;
    logic [CW-1:0]    gnt_idx;
    logic             slot_free;
    logic             xfer;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]    out_ch_q, out_ch_d;
    logic [CW-1:0]    ptr_q, ptr_d;

    // The output slot can take a beat when empty or being drained this cycle.
    assign slot_free = !out_valid_q || out_ready;
    // Grants only ever land on requesting channels, so any grant is a transfer.
    assign xfer      = |gnt;
    assign in_ready  = gnt;

    rr_arbiter #(
        .NCH (NCH),
        .CW  (CW)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .en      (slot_free && rst_n),
        .mode    (MODE == MODE_FIXED),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Next-state: load on transfer, empty on drain without refill, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_ch_d    = gnt_idx;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (gnt[i]) begin
                    out_data_d = in_data[i*WIDTH +: WIDTH];
                end
            end
            if (MODE == MODE_RR) begin
                ptr_d = (32'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + CW'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule
